fetch_buffer: RTL and testbench

FETCH_BUFFER -- requirements
Module: fetch_buffer

---
 rtl/fetch_buffer.sv | 108 ++++++++++
 tb/tb_fetch_buffer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_buffer.sv
// fetch_buffer: captures a free-running synchronous ROM stream into a small
// FIFO, tagging each word with the address that produced it.
// Optional feature: define FETCH_BUFFER_DROP_CNT_EN to count dropped words
// in drop_cnt (saturating at 255); otherwise drop_cnt is tied to zero.
module fetch_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               read_addr,
  input  logic [DATA_W-1:0]        rom_dout,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [7:0]               out_addr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [7:0]               drop_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [7:0]        r_addr_d;
  logic              r_wr_en;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_overflow;

  logic [DATA_W-1:0] r_mem_data [DEPTH];
  logic [7:0]        r_mem_addr [DEPTH];

  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign w_full = (r_count == CNT_W'(DEPTH));
  assign w_pop  = (r_count != '0) && out_ready;
  assign w_push = r_wr_en && (!w_full || w_pop);
  assign w_drop = r_wr_en && w_full && !w_pop;

  assign out_valid = (r_count != '0);
  assign out_data  = r_mem_data[r_rd_ptr];
  assign out_addr  = r_mem_addr[r_rd_ptr];
  assign count     = r_count;
  assign overflow  = r_overflow;

  // Address delay aligns the tag with the ROM's registered output; wr_en
  // holds off the first push until the ROM has produced a valid word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr_d <= '0;
      r_wr_en  <= 1'b0;
    end else begin
      r_addr_d <= read_addr;
      r_wr_en  <= 1'b1;
    end
  end

  // Pointer, occupancy and sticky overflow bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // Storage is not reset; its contents are only observed while out_valid=1.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= rom_dout;
      r_mem_addr[r_wr_ptr] <= r_addr_d;
    end
  end

`ifdef FETCH_BUFFER_DROP_CNT_EN
  logic [7:0] r_drop_cnt;

  // Saturating count of dropped words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != '1)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign drop_cnt = r_drop_cnt;
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed, table-driven bench for fetch_buffer (DEPTH=4, DATA_W=32),
// plus hand-written sequences for asynchronous reset and drop saturation.
module tb_fetch_buffer;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned DATA_W = 32;
`ifdef FETCH_BUFFER_DROP_CNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [7:0]        read_addr;
  logic [DATA_W-1:0] rom_dout;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [7:0]        out_addr;
  logic [2:0]        count;
  logic              overflow;
  logic [7:0]        drop_cnt;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  fetch_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .read_addr (read_addr),
    .rom_dout  (rom_dout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .count     (count),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [7:0] a);
    return {8'hA5, a, ~a, a ^ 8'h3C};
  endfunction

  // Synchronous ROM model: word for the address sampled at this edge.
  always @(posedge clk) rom_dout <= rom_word(read_addr);

  function automatic int unsigned xd(input int unsigned n);
    return DROP_EN ? n : 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst_n;
    logic [7:0]  addr;
    logic        ready;
    logic        exp_valid;
    logic [7:0]  exp_addr;
    int unsigned exp_count;
    logic        exp_ovf;
    int unsigned exp_drops;
  } vec_t;

  vec_t vecs[$];

  task automatic start_fresh();
    rst_n = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Fill n edges with out_ready=0, then assert reset mid-cycle and verify
  // it takes effect before the next edge, then check the restart timing.
  task automatic async_reset_check(input int unsigned n_edges);
    int unsigned ec;
    start_fresh();
    for (int unsigned k = 1; k <= n_edges; k++) begin
      read_addr = 8'(40 + k);
      @(posedge clk); #1;
    end
    ec = (n_edges - 1 > DEPTH) ? DEPTH : n_edges - 1;
    check($sformatf("pre_rst%0d_count", n_edges), 32'(count), ec);
    check($sformatf("pre_rst%0d_ovf", n_edges), 32'(overflow), 32'(n_edges - 1 > DEPTH));
    check($sformatf("pre_rst%0d_head", n_edges), 32'(out_addr), 32'd41);
    #3 rst_n = 1'b0;
    #1;
    check("async_valid", 32'(out_valid), 32'd0);
    check("async_count", 32'(count), 32'd0);
    check("async_ovf", 32'(overflow), 32'd0);
    check("async_drop", 32'(drop_cnt), 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    read_addr = 8'd77;
    @(posedge clk); #1;
    check("restart_e1_count", 32'(count), 32'd0);
    check("restart_e1_valid", 32'(out_valid), 32'd0);
    read_addr = 8'd78;
    @(posedge clk); #1;
    check("restart_e2_count", 32'(count), 32'd1);
    check("restart_e2_addr", 32'(out_addr), 32'd77);
    check("restart_e2_data", out_data, rom_word(8'd77));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    read_addr = 8'd0;
    out_ready = 1'b0;
    #1;
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_count", 32'(count), 32'd0);
    check("reset_ovf", 32'(overflow), 32'd0);
    check("reset_drop", 32'(drop_cnt), 32'd0);

    // Streaming with out_ready=1: one-deep pass-through after two edges.
    vecs.push_back('{1'b0, 8'd0,   1'b1, 1'b0, 8'd0,   0, 1'b0, 0});
    vecs.push_back('{1'b1, 8'd0,   1'b1, 1'b0, 8'd0,   0, 1'b0, 0});
    vecs.push_back('{1'b1, 8'd1,   1'b1, 1'b1, 8'd0,   1, 1'b0, 0});
    vecs.push_back('{1'b1, 8'd2,   1'b1, 1'b1, 8'd1,   1, 1'b0, 0});
    vecs.push_back('{1'b1, 8'd3,   1'b1, 1'b1, 8'd2,   1, 1'b0, 0});
    vecs.push_back('{1'b1, 8'd4,   1'b1, 1'b1, 8'd3,   1, 1'b0, 0});
    vecs.push_back('{1'b1, 8'd5,   1'b1, 1'b1, 8'd4,   1, 1'b0, 0});
    // Stall: fill to DEPTH, then two drops; then a pop+push at full.
    vecs.push_back('{1'b0, 8'd9,   1'b0, 1'b0, 8'd0,   0, 1'b0, 0});
    vecs.push_back('{1'b1, 8'd10,  1'b0, 1'b0, 8'd0,   0, 1'b0, 0});
    vecs.push_back('{1'b1, 8'd11,  1'b0, 1'b1, 8'd10,  1, 1'b0, 0});
    vecs.push_back('{1'b1, 8'd12,  1'b0, 1'b1, 8'd10,  2, 1'b0, 0});
    vecs.push_back('{1'b1, 8'd13,  1'b0, 1'b1, 8'd10,  3, 1'b0, 0});
    vecs.push_back('{1'b1, 8'd14,  1'b0, 1'b1, 8'd10,  4, 1'b0, 0});
    vecs.push_back('{1'b1, 8'd15,  1'b0, 1'b1, 8'd10,  4, 1'b1, 1});
    vecs.push_back('{1'b1, 8'd16,  1'b0, 1'b1, 8'd10,  4, 1'b1, 2});
    vecs.push_back('{1'b1, 8'd17,  1'b1, 1'b1, 8'd11,  4, 1'b1, 2});
    vecs.push_back('{1'b1, 8'd18,  1'b1, 1'b1, 8'd12,  4, 1'b1, 2});
    // Address wrap 254,255,0,1 is ordinary data.
    vecs.push_back('{1'b0, 8'd250, 1'b1, 1'b0, 8'd0,   0, 1'b0, 0});
    vecs.push_back('{1'b1, 8'd254, 1'b1, 1'b0, 8'd0,   0, 1'b0, 0});
    vecs.push_back('{1'b1, 8'd255, 1'b1, 1'b1, 8'd254, 1, 1'b0, 0});
    vecs.push_back('{1'b1, 8'd0,   1'b1, 1'b1, 8'd255, 1, 1'b0, 0});
    vecs.push_back('{1'b1, 8'd1,   1'b1, 1'b1, 8'd0,   1, 1'b0, 0});
    vecs.push_back('{1'b1, 8'd2,   1'b1, 1'b1, 8'd1,   1, 1'b0, 0});

    for (int i = 0; i < vecs.size(); i++) begin
      rst_n     = vecs[i].rst_n;
      read_addr = vecs[i].addr;
      out_ready = vecs[i].ready;
      @(posedge clk); #1;
      check($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
      check($sformatf("v%0d_count", i), 32'(count), vecs[i].exp_count);
      check($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vecs[i].exp_ovf));
      check($sformatf("v%0d_drop", i), 32'(drop_cnt), xd(vecs[i].exp_drops));
      if (vecs[i].exp_valid) begin
        check($sformatf("v%0d_addr", i), 32'(out_addr), 32'(vecs[i].exp_addr));
        check($sformatf("v%0d_data", i), out_data, rom_word(vecs[i].exp_addr));
      end
    end

    // Mid-operation reset at count=3, then at full with overflow set.
    async_reset_check(4);
    async_reset_check(7);

    // Drop saturation: edge k>=6 drops a word, so drops = k-5.
    start_fresh();
    for (int unsigned k = 1; k <= 270; k++) begin
      read_addr = 8'(k);
      @(posedge clk); #1;
      if (k == 259) check("sat_drop_254", 32'(drop_cnt), xd(254));
      if (k == 260) check("sat_drop_255", 32'(drop_cnt), xd(255));
    end
    check("sat_drop_final", 32'(drop_cnt), xd(255));
    check("sat_count", 32'(count), 32'd4);
    check("sat_ovf", 32'(overflow), 32'd1);
    check("sat_head_addr", 32'(out_addr), 32'd1);
    check("sat_head_data", out_data, rom_word(8'd1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
